// File: rtl/sync_pkt_fifo.sv
// Single-clock frame FIFO: words become readable only once their frame's last word commits; drop rewinds to last commit.
// Latency: FALLTHROUGH="TRUE" shows head word combinationally, "FALSE" one cycle after rinc; writes stall on wfull, overflow auto-drops.
module sync_pkt_fifo #(
    parameter int    DSIZE       = 8,
    parameter int    ASIZE       = 4,
    parameter int    ALMOST      = 2,
    parameter string FALLTHROUGH = "TRUE"
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    input  logic             wlast,
    input  logic             wdrop,
    output logic             wfull,
    output logic             awfull,
    output logic             werr,
    output logic [ASIZE:0]   wlevel,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rlast,
    output logic             rempty,
    output logic             arempty,
    output logic [ASIZE:0]   rlevel,
    output logic [ASIZE:0]   pkt_cnt
);

    localparam int DEPTH = 1 << ASIZE;
    localparam int AWF   = DEPTH - ALMOST;

    localparam logic [ASIZE:0] LVL_FULL    = DEPTH[ASIZE:0];
    localparam logic [ASIZE:0] LVL_AWFULL  = AWF[ASIZE:0];
    localparam logic [ASIZE:0] LVL_AREMPTY = ALMOST[ASIZE:0];
    localparam logic [ASIZE:0] PTR_ONE     = {{ASIZE{1'b0}}, 1'b1};

    typedef struct packed {
        logic             last;
        logic [DSIZE-1:0] dat;
    } entry_t;

    logic [ASIZE:0] wptr;
    logic [ASIZE:0] cptr;
    logic [ASIZE:0] rptr;
    logic           ovf;
    logic           werr_q;
    logic [ASIZE:0] pkt_q;

    entry_t mem [DEPTH];
    entry_t rd_ent;

    logic wr_acc;
    logic commit;
    logic rd_acc;
    logic rd_last;
    logic ovf_end;

    // Levels and flags derive only from registered pointers, so they lag the edge by nothing combinational.
    assign wlevel  = wptr - rptr;
    assign rlevel  = cptr - rptr;
    assign wfull   = (wlevel == LVL_FULL);
    assign awfull  = (wlevel >= LVL_AWFULL);
    assign rempty  = (cptr == rptr);
    assign arempty = (rlevel <= LVL_AREMPTY);
    assign werr    = werr_q;
    assign pkt_cnt = pkt_q;

    assign rd_ent  = mem[rptr[ASIZE-1:0]];

    // wdrop outranks everything on the write side; an overflowed frame swallows words until its wlast.
    assign wr_acc  = winc && !wfull && !ovf && !wdrop;
    assign commit  = wr_acc && wlast;
    assign ovf_end = ovf && !wdrop && winc && wlast;
    assign rd_acc  = rinc && !rempty;
    assign rd_last = rd_acc && rd_ent.last;

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr[ASIZE-1:0]] <= '{last: wlast, dat: wdata};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            cptr <= '0;
        end else begin
            if (wdrop || ovf_end) begin
                wptr <= cptr;
            end else if (wr_acc) begin
                wptr <= wptr + PTR_ONE;
            end
            if (commit) begin
                cptr <= wptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf    <= 1'b0;
            werr_q <= 1'b0;
        end else begin
            werr_q <= ovf_end;
            if (wdrop || ovf_end) begin
                ovf <= 1'b0;
            end else if (winc && wfull) begin
                ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr <= '0;
        end else if (rd_acc) begin
            rptr <= rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_q <= '0;
        end else begin
            case ({commit, rd_last})
                2'b10:   pkt_q <= pkt_q + PTR_ONE;
                2'b01:   pkt_q <= pkt_q - PTR_ONE;
                default: pkt_q <= pkt_q;
            endcase
        end
    end

    if (FALLTHROUGH == "TRUE") begin : g_fwft
        assign rdata = rempty ? '0 : rd_ent.dat;
        assign rlast = !rempty && rd_ent.last;
    end else begin : g_regd
        entry_t rd_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_q <= '0;
            end else if (rd_acc) begin
                rd_q <= rd_ent;
            end
        end

        assign rdata = rd_q.dat;
        assign rlast = rd_q.last;
    end

    // Commit point always sits between read and speculative write pointers.
    ast_wlevel_bound: assert property (@(posedge clk) disable iff (rst) wlevel <= LVL_FULL);
    ast_commit_order: assert property (@(posedge clk) disable iff (rst) rlevel <= wlevel);

endmodule

// File: tb/tb_sync_pkt_fifo.sv
// Drives a fall-through and a registered-output instance with identical stimulus, checked
// against a queue-based frame model; read data is scoreboarded by per-instance monitors.
module tb_sync_pkt_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       winc, wlast, wdrop, rinc;
    logic [7:0] wdata;

    logic       ft_wfull, ft_awfull, ft_werr, ft_rlast, ft_rempty, ft_arempty;
    logic [4:0] ft_wlevel, ft_rlevel, ft_pkt_cnt;
    logic [7:0] ft_rdata;
    logic       rg_wfull, rg_awfull, rg_werr, rg_rlast, rg_rempty, rg_arempty;
    logic [4:0] rg_wlevel, rg_rlevel, rg_pkt_cnt;
    logic [7:0] rg_rdata;

    int checks   = 0;
    int failures = 0;

    // Model: committed-unread words, uncommitted words, overflow state.
    logic [8:0] cq[$];
    logic [8:0] pq[$];
    logic [8:0] sb_ft[$];
    logic [8:0] sb_rg[$];
    bit         m_ovf  = 1'b0;
    bit         m_werr = 1'b0;
    logic [8:0] rg_hold = '0;

    always #5 clk = ~clk;

    sync_pkt_fifo #(.DSIZE(8), .ASIZE(4), .ALMOST(2), .FALLTHROUGH("TRUE")) u_ft (
        .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .wlast(wlast), .wdrop(wdrop),
        .wfull(ft_wfull), .awfull(ft_awfull), .werr(ft_werr), .wlevel(ft_wlevel),
        .rinc(rinc), .rdata(ft_rdata), .rlast(ft_rlast), .rempty(ft_rempty),
        .arempty(ft_arempty), .rlevel(ft_rlevel), .pkt_cnt(ft_pkt_cnt)
    );

    sync_pkt_fifo #(.DSIZE(8), .ASIZE(4), .ALMOST(2), .FALLTHROUGH("FALSE")) u_rg (
        .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .wlast(wlast), .wdrop(wdrop),
        .wfull(rg_wfull), .awfull(rg_awfull), .werr(rg_werr), .wlevel(rg_wlevel),
        .rinc(rinc), .rdata(rg_rdata), .rlast(rg_rlast), .rempty(rg_rempty),
        .arempty(rg_arempty), .rlevel(rg_rlevel), .pkt_cnt(rg_pkt_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack(input logic full, input logic afull, input logic err,
                                         input logic [4:0] wl, input logic empty, input logic aempty,
                                         input logic [4:0] rl, input logic [4:0] pk);
        return {12'd0, full, afull, err, wl, empty, aempty, rl, pk};
    endfunction

    function automatic logic [31:0] exp_status();
        int wl = cq.size() + pq.size();
        int rl = cq.size();
        int pk = 0;
        foreach (cq[i]) if (cq[i][8]) pk++;
        return pack(wl == 16, wl >= 14, m_werr, 5'(wl), rl == 0, rl <= 2, 5'(rl), 5'(pk));
    endfunction

    task automatic check_status();
        chk("ft_status", pack(ft_wfull, ft_awfull, ft_werr, ft_wlevel, ft_rempty, ft_arempty,
                              ft_rlevel, ft_pkt_cnt), exp_status());
        chk("rg_status", pack(rg_wfull, rg_awfull, rg_werr, rg_wlevel, rg_rempty, rg_arempty,
                              rg_rlevel, rg_pkt_cnt), exp_status());
    endtask

    // Applies one edge's worth of frame rules to the queues using the inputs now driven.
    task automatic model_step();
        int wl = cq.size() + pq.size();
        m_werr = 1'b0;
        if (rinc && cq.size() > 0) void'(cq.pop_front());
        if (wdrop) begin
            pq.delete();
            m_ovf = 1'b0;
        end else if (m_ovf) begin
            if (winc && wlast) begin
                pq.delete();
                m_ovf  = 1'b0;
                m_werr = 1'b1;
            end
        end else if (winc) begin
            if (wl == 16) begin
                m_ovf = 1'b1;
            end else begin
                pq.push_back({wlast, wdata});
                if (wlast) begin
                    foreach (pq[i]) begin
                        cq.push_back(pq[i]);
                        sb_ft.push_back(pq[i]);
                        sb_rg.push_back(pq[i]);
                    end
                    pq.delete();
                end
            end
        end
    endtask

    // Called one time unit after a rising edge.
    task automatic cyc(input bit w, input logic [7:0] d, input bit l, input bit dr, input bit r);
        check_status();
        winc  = w;
        wdata = d;
        wlast = l;
        wdrop = dr;
        rinc  = r;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && cq.size() > 0; i++) cyc(0, 8'h00, 0, 0, 1);
        cyc(0, 8'h00, 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst && rinc && !ft_rempty) begin
            if (sb_ft.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL ft_extra_read act=%0h exp=none", {ft_rlast, ft_rdata});
            end else begin
                e = sb_ft.pop_front();
                chk("ft_rdata", 32'({ft_rlast, ft_rdata}), 32'(e));
            end
        end
    end

    // Registered mode: output must hold the last popped word until the next pop.
    always @(negedge clk) begin
        if (rst) begin
            rg_hold = '0;
        end else begin
            chk("rg_rdata", 32'({rg_rlast, rg_rdata}), 32'(rg_hold));
            if (rinc && !rg_rempty) begin
                if (sb_rg.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rg_extra_read act=%0h exp=none", {rg_rlast, rg_rdata});
                end else begin
                    rg_hold = sb_rg.pop_front();
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; winc = 0; wdata = '0; wlast = 0; wdrop = 0; rinc = 0;
        #2 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_status();
        chk("rg_reset_rdata", 32'({rg_rlast, rg_rdata}), 32'd0);
        rst = 1'b0;

        // Single frame
        cyc(1, 8'h11, 0, 0, 0);
        cyc(1, 8'h22, 0, 0, 0);
        chk("single_rempty_before", 32'(ft_rempty), 32'd1);
        cyc(1, 8'h33, 1, 0, 0);
        chk("single_rlevel", 32'(ft_rlevel), 32'd3);
        chk("single_pkt", 32'(rg_pkt_cnt), 32'd1);
        repeat (3) cyc(0, 8'h00, 0, 0, 1);
        cyc(0, 8'h00, 0, 0, 0);
        chk("single_empty_after", 32'({ft_rempty, rg_rempty}), 32'h3);
        chk("single_pkt_after", 32'(ft_pkt_cnt), 32'd0);

        // Drop mid-frame, then a clean 2-word frame
        for (int i = 0; i < 5; i++) cyc(1, 8'(8'h40 + i), 0, 0, 0);
        chk("drop_wlevel_pre", 32'(ft_wlevel), 32'd5);
        cyc(0, 8'h00, 0, 1, 0);
        chk("drop_wlevel_post", 32'(ft_wlevel), 32'd0);
        cyc(1, 8'h5A, 0, 0, 0);
        cyc(1, 8'hA5, 1, 0, 0);
        drain();

        // Overflow: 14-word frame A, frame B overruns and is auto-dropped
        for (int i = 0; i < 14; i++) cyc(1, 8'(8'h80 + i), i == 13, 0, 0);
        chk("ovf_awfull", 32'({ft_awfull, ft_wfull}), 32'h2);
        cyc(1, 8'hB0, 0, 0, 0);
        cyc(1, 8'hB1, 0, 0, 0);
        chk("ovf_wfull", 32'({ft_wfull, rg_wfull}), 32'h3);
        cyc(1, 8'hB2, 0, 0, 0);
        cyc(1, 8'hB3, 0, 0, 0);
        cyc(1, 8'hB4, 1, 0, 0);
        chk("ovf_werr_pulse", 32'({ft_werr, rg_werr}), 32'h3);
        cyc(0, 8'h00, 0, 0, 0);
        chk("ovf_werr_clear", 32'(ft_werr), 32'd0);
        chk("ovf_wlevel", 32'(ft_wlevel), 32'd14);
        chk("ovf_pkt", 32'(ft_pkt_cnt), 32'd1);
        drain();

        // Commit on the same edge as the last read of the previous frame
        cyc(1, 8'h01, 1, 0, 0);
        cyc(1, 8'h02, 1, 0, 1);
        chk("simul_rempty", 32'({ft_rempty, rg_rempty}), 32'd0);
        chk("simul_pkt", 32'(ft_pkt_cnt), 32'd1);
        drain();

        // Wrap-around: back-to-back 3-word frames with concurrent reads
        for (int f = 0; f < 40; f++) begin
            for (int k = 0; k < 3; k++)
                cyc(1, 8'($urandom), k == 2, 0, $urandom_range(0, 7) != 0);
            if ($urandom_range(0, 1) == 1) cyc(0, 8'h00, 0, 0, 1);
        end
        drain();

        // Random mix including drops and overflow
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) == 0,
                $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
        drain();

        // Async reset mid-frame with 6 committed words
        for (int i = 0; i < 6; i++) cyc(1, 8'(8'hC0 + i), i == 5, 0, 0);
        cyc(1, 8'hD0, 0, 0, 0);
        cyc(1, 8'hD1, 0, 0, 1);
        #2;
        rst = 1'b1;
        winc = 0; wlast = 0; wdrop = 0; rinc = 0;
        #1;
        chk("rst_ft_status", pack(ft_wfull, ft_awfull, ft_werr, ft_wlevel, ft_rempty, ft_arempty,
                                  ft_rlevel, ft_pkt_cnt), pack(0, 0, 0, 5'd0, 1, 1, 5'd0, 5'd0));
        chk("rst_rg_status", pack(rg_wfull, rg_awfull, rg_werr, rg_wlevel, rg_rempty, rg_arempty,
                                  rg_rlevel, rg_pkt_cnt), pack(0, 0, 0, 5'd0, 1, 1, 5'd0, 5'd0));
        chk("rst_rg_rdata", 32'({rg_rlast, rg_rdata}), 32'd0);
        cq.delete(); pq.delete(); sb_ft.delete(); sb_rg.delete();
        m_ovf = 1'b0; m_werr = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1, 8'hAA, 0, 0, 0);
        cyc(1, 8'hBB, 1, 0, 0);
        drain();

        chk("ft_sb_left", 32'(sb_ft.size()), 32'd0);
        chk("rg_sb_left", 32'(sb_rg.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_pkt_fifo.md
Name: sync_pkt_fifo

Overview:
- Single-clock, parametrised successor to the team's dual-clock FIFO, for the Ethernet datapath.
- Buffers frames word-by-word. A frame becomes readable only after its last word is committed.
- A frame can be discarded mid-write, e.g. on bad CRC, by rewinding to the last commit point.
- Adds per-frame boundaries, a drop/overflow mechanism, occupancy levels and a committed-packet count.

Parameters:
- DSIZE, 8, data word width.
- ASIZE, 4, address width; DEPTH = 2**ASIZE words.
- ALMOST, 2, margin for the awfull/arempty thresholds; legal range 1..DEPTH-1.
- FALLTHROUGH, "TRUE", first-word fall-through ("TRUE") or registered read data ("FALSE").

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- winc  in  1  write request.
- wdata  in  DSIZE  write data.
- wlast  in  1  qualifies wdata as the last word of a frame.
- wdrop  in  1  discard the frame currently being written.
- wfull  out  1  wlevel == DEPTH.
- awfull  out  1  wlevel >= DEPTH-ALMOST.
- werr  out  1  one-cycle pulse: frame auto-dropped due to overflow.
- wlevel  out  ASIZE+1  words stored, including uncommitted words.
- rinc  in  1  read request.
- rdata  out  DSIZE  read data.
- rlast  out  1  last-word flag travelling with rdata.
- rempty  out  1  no committed words.
- arempty  out  1  rlevel <= ALMOST.
- rlevel  out  ASIZE+1  committed words not yet read.
- pkt_cnt  out  ASIZE+1  committed frames not yet fully read.

Behaviour:
- Pointers: three (ASIZE+1)-bit registers: wptr (speculative write), cptr (commit), rptr (read). The extra MSB disambiguates full from empty; all pointer arithmetic is modulo 2**(ASIZE+1).
- Memory: DEPTH x (DSIZE+1), storing {wlast, wdata}.
- Levels: wlevel = wptr-rptr, rlevel = cptr-rptr. All flags are combinational from registered pointers, so pointer changes are visible the cycle after the edge.
- Write accept: winc && !wfull && !ovf stores the word at wptr[ASIZE-1:0] and increments wptr.
- Commit: an accepted word with wlast=1 and wdrop=0 sets cptr <= wptr+1.
- Drop: wdrop=1 sets wptr <= cptr and discards any word presented the same cycle. wdrop has priority over wlast and over accept. No effect on the read side.
- Overflow: winc while wfull sets sticky ovf. While ovf=1, writes are ignored.
  - On the next winc with wlast=1, or on wdrop: wptr <= cptr, ovf <= 0.
  - werr pulses for one cycle only for the wlast case.
- Read side: rempty = (cptr == rptr). rinc && !rempty increments rptr; rinc while rempty is ignored with no state change.
- FALLTHROUGH "TRUE": rdata/rlast = mem[rptr] combinationally whenever !rempty; rinc pops the shown word (zero latency).
- FALLTHROUGH "FALSE": rdata/rlast are registered, loaded from mem[rptr] on the edge where rinc && !rempty (one-cycle latency), and otherwise held.
- pkt_cnt: +1 on commit, -1 when a popped word has rlast=1. Both in the same cycle leaves it unchanged.
- Simultaneous write and read: legal in the same cycle, including when full.
  - A read while full does not free space for a write in the same cycle, because wfull is computed from pre-edge pointers.
  - A commit and the read of the last committed word in the same cycle leaves rempty=0 next cycle.
- Reset values: wptr=cptr=rptr=0, ovf=0, werr=0, wfull=0, awfull=0, wlevel=0, rlevel=0, pkt_cnt=0, rempty=1, arempty=1. In "FALSE" mode rdata=0 and rlast=0.
- Reset mid-frame or mid-read discards all contents; the first frame after reset starts clean.
- Memory contents are not reset.

Test Plan (ASIZE=4, ALMOST=2, both FALLTHROUGH modes):
- Single frame: write 0x11,0x22,0x33 with wlast on 0x33.
  - rempty stays 1 until the cycle after 0x33 is written, then rempty=0, rlevel=3, pkt_cnt=1.
  - Three reads return 0x11,0x22,0x33 with rlast only on 0x33 ("FALSE" mode: each one cycle after rinc); then rempty=1, pkt_cnt=0.
- Drop: write 5 words without wlast, then assert wdrop.
  - wlevel returns 5->0, rempty never deasserts, pkt_cnt=0.
  - A following 2-word frame reads back intact.
- Overflow:
  - Commit a 14-word frame (awfull=1 at wlevel=14).
  - Write 2 words of frame B, then attempt 3 more with wlast on the final one (wfull=1 at wlevel=16).
  - werr pulses once, wlevel returns to 14, pkt_cnt=1, frame A reads back exact.
- Wrap-around: 40 back-to-back 3-word frames with concurrent reads.
  - Order and data preserved across pointer wrap.
  - wfull never falsely asserts when wlevel<16.
- Simultaneous: commit a 1-word frame on the same edge as the last read of the previous frame → rempty stays 0, pkt_cnt unchanged at 1.
- Reset: assert rst mid-frame with 6 committed words → all outputs at reset values immediately (async). After release, a new frame of 0xAA,0xBB reads back as 0xAA,0xBB.
